// File: rtl/prog_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator datapath: PC, IR, jumps, halt, retire counter.
// Optional single-step support is enabled with `define PROG_SEQUENCER_SINGLE_STEP_EN.
module prog_sequencer #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INSTR_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef PROG_SEQUENCER_SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               load_a,
    output logic               load_b,
    output logic               sel_b,
    output logic [1:0]         alu_s,
    output logic [3:0]         imm,
    output logic               busy,
    output logic               halted,
    output logic               flag_z,
    output logic [7:0]         instr_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] FLOW_NONE = 2'b00;
    localparam logic [1:0] FLOW_JMP  = 2'b01;
    localparam logic [1:0] FLOW_JEQ  = 2'b10;
    localparam logic [1:0] FLOW_HALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
`ifdef PROG_SEQUENCER_SINGLE_STEP_EN
        ST_PAUSE  = 3'd4,
`endif
        ST_HALTED = 3'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               flag_z_q, flag_z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_a_q, load_a_d;
    logic               load_b_q, load_b_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    logic [1:0]         flow;
    logic               exec_load;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  target;

    // Next-state, next-PC and registered-output computation
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flag_z_d  = flag_z_q;
        cnt_d     = cnt_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        busy_d    = 1'b0;
        halted_d  = 1'b0;

        flow      = ir_q[10:9];
        exec_load = (flow == FLOW_NONE) && (ir_q[6] || ir_q[7]);
        pc_inc    = pc_q + ADDR_W'(1);
        target    = ADDR_W'(ir_q[3:0]);

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = '0;
                    cnt_d    = '0;
                    flag_z_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (exec_load) begin
                    flag_z_d = (alu_out == '0);
                end
                case (flow)
                    FLOW_NONE: pc_d = pc_inc;
                    FLOW_JMP:  pc_d = target;
                    FLOW_JEQ:  pc_d = flag_z_q ? target : pc_inc;
                    default:   pc_d = pc_q;
                endcase
                if (flow == FLOW_HALT) begin
                    state_d = ST_HALTED;
                end
`ifdef PROG_SEQUENCER_SINGLE_STEP_EN
                else if (step_mode) begin
                    state_d = ST_PAUSE;
                end
`endif
                else begin
                    state_d = ST_FETCH;
                end
            end
`ifdef PROG_SEQUENCER_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Loads pulse for the one EXEC cycle of a NONE-flow instruction
        load_a_d = (state_d == ST_EXEC) && (ir_d[10:9] == FLOW_NONE) && ir_d[6];
        load_b_d = (state_d == ST_EXEC) && (ir_d[10:9] == FLOW_NONE) && ir_d[7];
`ifdef PROG_SEQUENCER_SINGLE_STEP_EN
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_PAUSE);
`else
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC);
`endif
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            flag_z_q <= 1'b0;
            cnt_q    <= '0;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flag_z_q <= flag_z_d;
            cnt_q    <= cnt_d;
            load_a_q <= load_a_d;
            load_b_q <= load_b_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Datapath controls come straight from IR so they hold for the whole instruction
    assign imem_addr   = pc_q;
    assign sel_b       = ir_q[8];
    assign alu_s       = ir_q[5:4];
    assign imm         = ir_q[3:0];
    assign load_a      = load_a_q;
    assign load_b      = load_b_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign flag_z      = flag_z_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: an instruction-level reference model predicts every
// retirement, and a cycle monitor compares each retired instruction against the queue.
module tb_prog_sequencer;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INSTR_W = 11;
    localparam int unsigned DEPTH   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [DATA_W-1:0]  alu_out = '0;
    logic               load_a, load_b, sel_b;
    logic [1:0]         alu_s;
    logic [3:0]         imm;
    logic               busy, halted, flag_z;
    logic [7:0]         instr_count;

    logic [INSTR_W-1:0] imem [DEPTH];

    prog_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data), .alu_out(alu_out),
        .load_a(load_a), .load_b(load_b), .sel_b(sel_b), .alu_s(alu_s), .imm(imm),
        .busy(busy), .halted(halted), .flag_z(flag_z), .instr_count(instr_count)
    );

    assign imem_data = imem[imem_addr];
    always #5 clk = ~clk;

    typedef struct {
        bit la;
        bit lb;
        bit selb;
        int alus;
        int imm;
        int z;
        int cnt;
        int pc;
        int halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void chk(string name, int act, int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endfunction

    // Instruction-level interpreter: one queue entry per retired instruction
    function automatic bit model_run(int alu, int cap);
        int   pc = 0;
        int   z = 0;
        int   cnt = 0;
        int   ins;
        int   ft;
        int   pc_n;
        bit   h = 1'b0;
        exp_t e;
        for (int n = 0; n < cap; n++) begin
            ins    = int'(imem[pc]);
            ft     = (ins >> 9) & 3;
            e.la   = (ft == 0) && (ins[6] == 1'b1);
            e.lb   = (ft == 0) && (ins[7] == 1'b1);
            e.selb = (ins[8] == 1'b1);
            e.alus = (ins >> 4) & 3;
            e.imm  = ins & 15;
            if (e.la || e.lb) z = (alu == 0) ? 1 : 0;
            if (ft == 1)                pc_n = ins & 15;
            else if (ft == 2 && z == 1) pc_n = ins & 15;
            else if (ft == 3)           pc_n = pc;
            else                        pc_n = (pc + 1) % DEPTH;
            if (cnt < 255) cnt++;
            e.z      = z;
            e.cnt    = cnt;
            e.pc     = pc_n;
            e.halted = (ft == 3) ? 1 : 0;
            exp_q.push_back(e);
            pc = pc_n;
            if (ft == 3) begin
                h = 1'b1;
                break;
            end
        end
        return h;
    endfunction

    // Monitor: busy cycles alternate FETCH/EXEC; results are checked the cycle after EXEC
    bit   exec_next = 1'b0;
    bit   post_pending = 1'b0;
    bit   cap_la, cap_lb, cap_selb;
    int   cap_alus, cap_imm;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            exec_next    = 1'b0;
            post_pending = 1'b0;
        end else begin
            if (post_pending) begin
                post_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got retirement expected none at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    chk("exec_load_a", int'(cap_la), int'(cur.la));
                    chk("exec_load_b", int'(cap_lb), int'(cur.lb));
                    chk("sel_b", int'(cap_selb), int'(cur.selb));
                    chk("alu_s", cap_alus, cur.alus);
                    chk("imm", cap_imm, cur.imm);
                    chk("next_pc", int'(imem_addr), cur.pc);
                    chk("flag_z", int'(flag_z), cur.z);
                    chk("instr_count", int'(instr_count), cur.cnt);
                    chk("halted", int'(halted), cur.halted);
                    chk("busy", int'(busy), 1 - cur.halted);
                end
            end
            if (busy) begin
                if (exec_next) begin
                    cap_la       = load_a;
                    cap_lb       = load_b;
                    cap_selb     = sel_b;
                    cap_alus     = int'(alu_s);
                    cap_imm      = int'(imm);
                    post_pending = 1'b1;
                    exec_next    = 1'b0;
                end else begin
                    chk("fetch_loads", int'({load_a, load_b}), 0);
                    exec_next = 1'b1;
                end
            end else begin
                exec_next = 1'b0;
            end
        end
    end

    task automatic check_reset_state(string tag);
        chk({tag, "_load_a"}, int'(load_a), 0);
        chk({tag, "_load_b"}, int'(load_b), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_addr"}, int'(imem_addr), 0);
        chk({tag, "_count"}, int'(instr_count), 0);
        chk({tag, "_flag_z"}, int'(flag_z), 0);
    endtask

    task automatic abort_reset();
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_addr", int'(imem_addr), 0);
        chk("start_count", int'(instr_count), 0);
        chk("start_flag_z", int'(flag_z), 0);
        chk("start_busy", int'(busy), 1);
        chk("start_halted", int'(halted), 0);
    endtask

    task automatic run_prog(int alu, int cap, bit noise);
        bit h;
        int budget;
        int end_pc, end_cnt, end_z;
        alu_out = DATA_W'(alu);
        exp_q.delete();
        h       = model_run(alu, cap);
        end_pc  = exp_q[exp_q.size() - 1].pc;
        end_cnt = exp_q[exp_q.size() - 1].cnt;
        end_z   = exp_q[exp_q.size() - 1].z;
        do_start();
        budget = 0;
        while (exp_q.size() != 0 && budget < 2 * cap + 20) begin
            @(posedge clk);
            #1 budget++;
            start = noise && (exp_q.size() >= 2) && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d retirements still pending", exp_q.size());
            exp_q.delete();
            abort_reset();
        end else if (h) begin
            repeat (3) @(posedge clk);
            #1;
            chk("hold_halted", int'(halted), 1);
            chk("hold_busy", int'(busy), 0);
            chk("hold_addr", int'(imem_addr), end_pc);
            chk("hold_count", int'(instr_count), end_cnt);
            chk("hold_flag_z", int'(flag_z), end_z);
        end else begin
            abort_reset();
        end
    endtask

    task automatic fill(logic [INSTR_W-1:0] v);
        for (int i = 0; i < DEPTH; i++) imem[i] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ft;
        fill(11'h600);
        #3;
        check_reset_state("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Loads, JMP, JEQ taken (alu 0) and not taken (alu 7)
        fill(11'h600);
        imem[0] = 11'h04A;
        imem[1] = 11'h0C3;
        imem[2] = 11'h205;
        imem[5] = 11'h040;
        imem[6] = 11'h403;
        run_prog(0, 20, 1'b0);
        run_prog(7, 20, 1'b0);

        // HALT at address 4 after five instructions, restarted from HALTED
        fill(11'h600);
        imem[0] = 11'h04A;
        imem[1] = 11'h0C3;
        imem[2] = 11'h000;
        imem[3] = 11'h000;
        run_prog(int'($urandom_range(0, 255)), 20, 1'b0);
        run_prog(0, 20, 1'b0);

        // Sequential wrap 15 -> 0, then reset lands in the EXEC of a load_a
        fill(11'h04A);
        run_prog(3, 18, 1'b0);

        // Tight JMP 0 loop drives the counter into saturation
        fill(11'h200);
        run_prog(0, 300, 1'b0);

        // Random programs with stray start pulses while busy
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                ft = int'($urandom_range(0, 9));
                imem[i] = INSTR_W'($urandom_range(0, 511));
                if (ft >= 9)      imem[i][10:9] = 2'b11;
                else if (ft == 8) imem[i][10:9] = 2'b10;
                else if (ft >= 6) imem[i][10:9] = 2'b01;
                else              imem[i][10:9] = 2'b00;
            end
            run_prog(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255)), 40, 1'b1);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
